// File: rtl/uart_pkg.sv
// uart_pkg: shared 8N1 link constants, receiver state encoding and vote helper.
package uart_pkg;

  localparam int CLK_FREQ   = 100_000_000;
  localparam int BAUD       = 9600;
  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  // 2-of-3 majority of the three mid-bit samples
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider producing a one-clock tick every DIV clocks.
// Holding restart keeps the count at zero so the tick phase follows its release.
module uart_baud_tick #(
  parameter int DIV = 651
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // divider count: 0..DIV-1, cleared by restart
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt <= '0;
    else if (restart || cnt == LAST) cnt <= '0;
    else cnt <= cnt + CW'(1);
  end

  assign tick = !restart && (cnt == LAST);

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 receiver, OVERSAMPLE ticks per bit, 2-of-3 vote around mid-bit.
// A byte is delivered with a one-clock valid; a low stop bit gives a one-clock
// framing_error instead and leaves data untouched.
module uart_receiver #(
  parameter int CLK_FREQ   = uart_pkg::CLK_FREQ,
  parameter int BAUD       = uart_pkg::BAUD,
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          RxD,
  output logic [uart_pkg::DATA_BITS-1:0] data,
  output logic                          valid,
  output logic                          framing_error,
  output logic                          busy
);
  import uart_pkg::*;

  localparam int TICK_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int SW       = $clog2(OVERSAMPLE);
  localparam int IW       = $clog2(DATA_BITS);

  // vote samples sit on tick counts OS/2-1, OS/2, OS/2+1 (7,8,9 for 16x)
  localparam logic [SW-1:0] S_FIRST  = SW'(OVERSAMPLE/2 - 1);
  localparam logic [SW-1:0] S_MID    = SW'(OVERSAMPLE/2);
  localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE/2 + 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  logic                 rx_meta, rx_s;
  rx_state_t            state, state_n;
  logic                 tick, restart;
  logic [SW-1:0]        scnt, scnt_inc;
  logic [IW-1:0]        bidx;
  logic                 smp_a, smp_b;
  logic                 vote, decide;
  logic [DATA_BITS-1:0] shreg;
  logic                 shift_en, load_byte, frame_err;

  // two-flop synchroniser, idles high so reset looks like a quiet line
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RxD;
      rx_s    <= rx_meta;
    end
  end

  uart_baud_tick #(.DIV(TICK_DIV)) u_tick (
    .clock   (clock),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  // scnt counts ticks since the bit boundary; the power-of-two width wraps it
  assign scnt_inc = scnt + SW'(1);
  assign decide   = tick && (scnt_inc == S_LAST);
  assign vote     = majority3(smp_a, smp_b, rx_s);
  assign busy     = (state != IDLE);

  // state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // next state and per-decision strobes
  always_comb begin
    state_n   = state;
    restart   = 1'b0;
    shift_en  = 1'b0;
    load_byte = 1'b0;
    frame_err = 1'b0;
    case (state)
      IDLE: begin
        // divider held at zero so bit phase starts at the detected edge
        restart = 1'b1;
        if (!rx_s) state_n = START;
      end
      START: if (decide) state_n = vote ? IDLE : DATA;
      DATA: if (decide) begin
        shift_en = 1'b1;
        if (bidx == LAST_BIT) state_n = STOP;
      end
      STOP: if (decide) begin
        load_byte = vote;
        frame_err = !vote;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // sample counter, bit index and the first two vote samples
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scnt  <= '0;
      bidx  <= '0;
      smp_a <= 1'b0;
      smp_b <= 1'b0;
    end else begin
      if (state == IDLE) scnt <= '0;
      else if (tick)     scnt <= scnt_inc;
      if (state == IDLE) bidx <= '0;
      else if (shift_en) bidx <= bidx + IW'(1);
      if (tick && scnt_inc == S_FIRST) smp_a <= rx_s;
      if (tick && scnt_inc == S_MID)   smp_b <= rx_s;
    end
  end

  // LSB arrives first, so each voted bit enters at the MSB and shifts right
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) shreg <= '0;
    else if (shift_en) shreg <= {vote, shreg[DATA_BITS-1:1]};
  end

  // output byte and one-clock result strobes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data          <= '0;
      valid         <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      if (load_byte) data <= shreg;
      valid         <= load_byte;
      framing_error <= frame_err;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed and randomized 8N1 frames against a frame-level model.
// Scaled clock/baud (64 clocks per bit) keeps the run short.
module tb_uart_receiver;

  localparam int CLK_FREQ   = 6_400_000;
  localparam int BAUD       = 100_000;
  localparam int OVERSAMPLE = 16;
  localparam int BIT        = CLK_FREQ / BAUD;          // 64 clocks per bit
  localparam int TICK       = BIT / OVERSAMPLE;         // 4 clocks per tick
  // stop-bit decision ~9 + 9/16 bits after the edge, plus sync and output register
  localparam int LAT        = 9 * BIT + 9 * TICK + 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       RxD   = 1'b1;
  logic [7:0] data;
  logic       valid, framing_error, busy;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int edge_cyc   = 0;
  int n_valid    = 0;
  int n_fe       = 0;
  logic [7:0] last_good = 8'h00;
  logic [7:0] got_q[$];
  int         got_cyc[$];

  uart_receiver #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVERSAMPLE)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .RxD           (RxD),
    .data          (data),
    .valid         (valid),
    .framing_error (framing_error),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // pulse monitor: record bytes and error pulses; strobes exclusive and never back-to-back
  initial begin
    logic prev_pulse;
    prev_pulse = 1'b0;
    forever begin
      @(negedge clock);
      if (valid) begin
        got_q.push_back(data);
        got_cyc.push_back(cyc);
        n_valid++;
      end
      if (framing_error) n_fe++;
      if (valid || framing_error) begin
        compared++;
        assert (!(valid && framing_error) && !prev_pulse) else begin
          mismatched++;
          $error("FAIL pulse_excl: valid=%0b framing_error=%0b prev=%0b, required single exclusive pulse",
                 valid, framing_error, prev_pulse);
        end
      end
      prev_pulse = valid | framing_error;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    RxD = v;
    repeat (n) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] b, input int per, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    edge_cyc = cyc;
    for (int i = 0; i < 10; i++) hold(f[i], per);
    RxD = 1'b1;
  endtask

  // model: a high stop bit delivers the sent byte, a low one only an error pulse
  task automatic frame_step(input string tag, input logic [7:0] b, input int per,
                            input logic stop, input int gap);
    int v0, f0, lat;
    logic [7:0] obs_b;
    v0 = n_valid;
    f0 = n_fe;
    got_q.delete();
    got_cyc.delete();
    send_frame(b, per, stop);
    hold(1'b1, gap);
    if (stop) begin
      last_good = b;
      obs_b = (got_q.size() > 0) ? got_q[$] : 8'hxx;
      lat   = (got_cyc.size() > 0) ? got_cyc[$] - edge_cyc : -1;
      chk($sformatf("%s/valid_cnt", tag), n_valid - v0, 1);
      chk($sformatf("%s/fe_cnt", tag), n_fe - f0, 0);
      chk($sformatf("%s/byte", tag), obs_b, b);
      chk($sformatf("%s/latency_ok(lat=%0d)", tag, lat), (lat >= LAT - 2 && lat <= LAT + 2), 1);
    end else begin
      chk($sformatf("%s/valid_cnt", tag), n_valid - v0, 0);
      chk($sformatf("%s/fe_cnt", tag), n_fe - f0, 1);
    end
    chk($sformatf("%s/data", tag), data, last_good);
    chk($sformatf("%s/busy", tag), busy, 0);
  endtask

  initial begin
    int v0, f0;
    logic [7:0] rb;
    int per, gap;
    logic stop;

    // reset state
    @(negedge clock);
    reset = 1'b0;
    hold(1'b1, 4);
    chk("rst/data", data, 8'h00);
    chk("rst/valid", valid, 0);
    chk("rst/framing_error", framing_error, 0);
    chk("rst/busy", busy, 0);
    reset = 1'b1;
    hold(1'b1, 2 * BIT);

    // nominal frame
    frame_step("a5", 8'hA5, BIT, 1'b1, 2 * BIT);

    // short low glitch: rejected at the vote, no outputs
    v0 = n_valid; f0 = n_fe;
    edge_cyc = cyc;
    hold(1'b0, (3 * BIT) / 10);
    hold(1'b1, 20 - (3 * BIT) / 10);
    chk("glitch/busy_mid", busy, 1);
    hold(1'b1, 9 * TICK + 8 - 20);
    chk("glitch/busy_end", busy, 0);
    hold(1'b1, 2 * BIT);
    chk("glitch/valid_cnt", n_valid - v0, 0);
    chk("glitch/fe_cnt", n_fe - f0, 0);

    // bad stop bit: error pulse, previous byte retained
    frame_step("3c_fe", 8'h3C, BIT, 1'b0, 2 * BIT);

    // back-to-back with no idle gap
    frame_step("b2b_00", 8'h00, BIT, 1'b1, 0);
    frame_step("b2b_ff", 8'hFF, BIT, 1'b1, 2 * BIT);

    // reset during data bit 4 of 0x5A: partial byte discarded
    v0 = n_valid; f0 = n_fe;
    hold(1'b0, BIT);
    for (int i = 0; i < 4; i++) begin
      rb = 8'h5A;
      hold(rb[i], BIT);
    end
    hold(1'b1, BIT / 2);
    chk("rst_mid/busy_before", busy, 1);
    reset = 1'b0;
    hold(1'b1, 5);
    chk("rst_mid/busy_in_reset", busy, 0);
    chk("rst_mid/data_in_reset", data, 8'h00);
    reset = 1'b1;
    last_good = 8'h00;
    hold(1'b1, 12 * BIT);
    chk("rst_mid/valid_cnt", n_valid - v0, 0);
    chk("rst_mid/fe_cnt", n_fe - f0, 0);
    frame_step("81", 8'h81, BIT, 1'b1, 2 * BIT);

    // +/-3% bit period
    frame_step("55_slow", 8'h55, 66, 1'b1, 2 * BIT);
    frame_step("55_fast", 8'h55, 62, 1'b1, 2 * BIT);

    // randomized frames within tolerance; bad stop bits only when not slow
    for (int k = 0; k < 10; k++) begin
      rb   = 8'($urandom);
      per  = $urandom_range(62, 66);
      stop = (per <= BIT) ? ($urandom_range(0, 3) != 0) : 1'b1;
      gap  = $urandom_range(48, 128);
      frame_step($sformatf("rnd%0d", k), rb, per, stop, gap);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
